// File: rtl/display_arbiter_pkg.sv
// Shared types and constants for the display arbiter: requester/digit counts,
// blank codes, FSM state encodings and the round-robin search helper.
package display_arbiter_pkg;

    localparam int NUM_REQ    = 3;
    localparam int NUM_DIGITS = 4;
    localparam int REQ_IDX_W  = 2;
    localparam int DIGIT_W    = $clog2(NUM_DIGITS);

    localparam logic [3:0] SEL_OFF = 4'hF;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWN
    } arb_state_t;

    typedef enum logic {
        SCAN_BLANK,
        SCAN_DRIVE
    } scan_state_t;

    typedef struct packed {
        logic                 vld;
        logic [REQ_IDX_W-1:0] idx;
    } rr_pick_t;

    // First active requester searching from last+1 (mod NUM_REQ); last itself is checked last.
    function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0]   req,
                                         input logic [REQ_IDX_W-1:0] last);
        rr_pick_t p;
        int       c;
        p = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            c = int'(last) + i;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            if (!p.vld && req[REQ_IDX_W'(c)]) begin
                p.vld = 1'b1;
                p.idx = REQ_IDX_W'(c);
            end
        end
        return p;
    endfunction

    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [REQ_IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/nibble_seg.sv
// Hex nibble to active-low 7-segment glyph (bit 0 = A ... bit 6 = G).
// Purely combinational; no latency, no backpressure.
module nibble_seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = 7'h7F;
        case (nibble)
            4'h0: seg_n = 7'h40;
            4'h1: seg_n = 7'h79;
            4'h2: seg_n = 7'h24;
            4'h3: seg_n = 7'h30;
            4'h4: seg_n = 7'h19;
            4'h5: seg_n = 7'h12;
            4'h6: seg_n = 7'h02;
            4'h7: seg_n = 7'h78;
            4'h8: seg_n = 7'h00;
            4'h9: seg_n = 7'h10;
            4'hA: seg_n = 7'h08;
            4'hB: seg_n = 7'h03;
            4'hC: seg_n = 7'h46;
            4'hD: seg_n = 7'h21;
            4'hE: seg_n = 7'h06;
            4'hF: seg_n = 7'h0E;
            default: seg_n = 7'h7F;
        endcase
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner arbitration of a shared 4-digit 7-segment display with minimum hold tenure.
// Grant follows req by one cycle; level requests, no backpressure; display changes only at slot boundaries.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int HOLD_CYCLES  = 100_000_000,
    parameter int SCAN_CYCLES  = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [15:0]        data0,
    input  logic [15:0]        data1,
    input  logic [15:0]        data2,
    output logic [NUM_REQ-1:0] grant,
    output logic [3:0]         sel,
    output logic [7:0]         seg
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCAN_W-1:0] BLANK_LAST = SCAN_W'(BLANK_CYCLES - 1);
    localparam logic [SCAN_W-1:0] DRIVE_LAST = SCAN_W'(SCAN_CYCLES - BLANK_CYCLES - 1);

    arb_state_t           arb_state;
    logic [REQ_IDX_W-1:0] rr_last;
    logic [HOLD_W-1:0]    hold_cnt;
    rr_pick_t             pick;
    logic                 owner_req;
    logic                 others_req;
    logic                 hold_sat;
    logic                 release_grant;

    scan_state_t          scan_state;
    logic [SCAN_W-1:0]    phase_cnt;
    logic [DIGIT_W-1:0]   digit;
    logic [15:0]          owner_data;
    logic [3:0]           nibble;
    logic [6:0]           glyph;
    logic [3:0]           digit_sel;

    always_comb begin
        pick = rr_pick(req, rr_last);
    end

    assign owner_req     = |(req & grant);
    assign others_req    = |(req & ~grant);
    assign hold_sat      = (hold_cnt == HOLD_LAST);
    assign release_grant = !owner_req || (hold_sat && others_req);

    // rr_last doubles as the owner index while in ARB_OWN, so one search covers both
    // the idle pick and the hand-over (the owner is always the last candidate tried).
    always_ff @(posedge clk) begin
        if (rst) begin
            arb_state <= ARB_IDLE;
            grant     <= '0;
            rr_last   <= REQ_IDX_W'(2);
            hold_cnt  <= '0;
        end else begin
            case (arb_state)
                ARB_IDLE: begin
                    if (pick.vld) begin
                        arb_state <= ARB_OWN;
                        grant     <= idx_onehot(pick.idx);
                        rr_last   <= pick.idx;
                        hold_cnt  <= '0;
                    end
                end
                ARB_OWN: begin
                    if (release_grant) begin
                        hold_cnt <= '0;
                        if (pick.vld) begin
                            grant   <= idx_onehot(pick.idx);
                            rr_last <= pick.idx;
                        end else begin
                            arb_state <= ARB_IDLE;
                            grant     <= '0;
                        end
                    end else if (!hold_sat) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    arb_state <= ARB_IDLE;
                    grant     <= '0;
                end
            endcase
        end
    end

    always_comb begin
        owner_data = '0;
        if (grant[0]) begin
            owner_data = data0;
        end else if (grant[1]) begin
            owner_data = data1;
        end else if (grant[2]) begin
            owner_data = data2;
        end
    end

    assign nibble    = owner_data[{digit, 2'b00} +: 4];
    assign digit_sel = ~(4'b0001 << digit);

    nibble_seg u_nibble_seg (
        .nibble (nibble),
        .seg_n  (glyph)
    );

    // sel/seg are loaded only on phase transitions, so the glyph captured at
    // BLANK->DRIVE stays put for the slot regardless of later grant changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_state <= SCAN_BLANK;
            phase_cnt  <= '0;
            digit      <= '0;
            sel        <= SEL_OFF;
            seg        <= SEG_OFF;
        end else begin
            case (scan_state)
                SCAN_BLANK: begin
                    if (phase_cnt == BLANK_LAST) begin
                        scan_state <= SCAN_DRIVE;
                        phase_cnt  <= '0;
                        if (|grant) begin
                            sel <= digit_sel;
                            seg <= {1'b1, glyph};
                        end else begin
                            sel <= SEL_OFF;
                            seg <= SEG_OFF;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + SCAN_W'(1);
                    end
                end
                SCAN_DRIVE: begin
                    if (phase_cnt == DRIVE_LAST) begin
                        scan_state <= SCAN_BLANK;
                        phase_cnt  <= '0;
                        digit      <= digit + DIGIT_W'(1);
                        sel        <= SEL_OFF;
                        seg        <= SEG_OFF;
                    end else begin
                        phase_cnt <= phase_cnt + SCAN_W'(1);
                    end
                end
                default: begin
                    scan_state <= SCAN_BLANK;
                    phase_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with short hold/scan timing (hold 8, slot 4, blank 1).
module tb_display_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [15:0] data2;
    logic [2:0]  grant;
    logic [3:0]  sel;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;

    // Expected sel/seg over one full 4-slot frame with owner 0 holding data 16'h1A3F.
    logic [3:0] frame_sel [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                   4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    logic [7:0] frame_seg [16] = '{8'hFF, 8'h8E, 8'h8E, 8'h8E, 8'hFF, 8'hB0, 8'hB0, 8'hB0,
                                   8'hFF, 8'h88, 8'h88, 8'h88, 8'hFF, 8'hF9, 8'hF9, 8'hF9};

    display_arbiter #(
        .HOLD_CYCLES  (8),
        .SCAN_CYCLES  (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data0 (data0),
        .data1 (data1),
        .data2 (data2),
        .grant (grant),
        .sel   (sel),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the last reset edge (frame position 0), requests applied.
    task automatic do_reset(input logic [2:0] r);
        rst = 1'b1;
        req = 3'b000;
        tick();
        tick();
        req = r;
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req   = 3'b000;
        data0 = 16'h1A3F;
        data1 = 16'h5C6D;
        data2 = 16'h9876;

        // Reset state, first grant and hold-based rotation
        do_reset(3'b011);
        chk("rst_grant", 16'(grant), 16'h0);
        chk("rst_sel", 16'(sel), 16'hF);
        chk("rst_seg", 16'(seg), 16'hFF);
        tick();
        chk("first_grant", 16'(grant), 16'h1);
        repeat (4) tick();
        chk("slot1_sel", 16'(sel), 16'hD);
        chk("slot1_seg", 16'(seg), 16'hB0);
        repeat (3) tick();
        chk("hold_tenure8", 16'(grant), 16'h1);
        tick();
        chk("hold_rotate", 16'(grant), 16'h2);
        chk("rotate_slot2_sel", 16'(sel), 16'hB);
        chk("rotate_slot2_seg", 16'(seg), 16'h88);
        repeat (8) tick();
        chk("rotate_back", 16'(grant), 16'h1);

        // Early release hands straight to the waiting requester
        do_reset(3'b101);
        tick();
        chk("early_first", 16'(grant), 16'h1);
        repeat (2) tick();
        chk("early_cycle3", 16'(grant), 16'h1);
        req = 3'b100;
        tick();
        chk("early_handover", 16'(grant), 16'h4);

        // Sole requester keeps the display, then everything goes dark
        do_reset(3'b010);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("sole_keep", 16'(grant), 16'h2);
        end
        req = 3'b000;
        tick();
        chk("sole_release", 16'(grant), 16'h0);
        chk("sole_tail_sel", 16'(sel), 16'hE);
        chk("sole_tail_seg", 16'(seg), 16'hA1);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("idle_sel", 16'(sel), 16'hF);
            chk("idle_seg", 16'(seg), 16'hFF);
        end

        // Full scan frame for owner 0
        do_reset(3'b001);
        repeat (15) tick();
        for (int p = 0; p < 16; p++) begin
            tick();
            chk("frame_sel", 16'(sel), 16'(frame_sel[p]));
            chk("frame_seg", 16'(seg), 16'(frame_seg[p]));
        end

        // Owner change during the digit-2 DRIVE phase
        do_reset(3'b001);
        repeat (9) tick();
        chk("mid_d2_sel", 16'(sel), 16'hB);
        chk("mid_d2_seg", 16'(seg), 16'h88);
        req = 3'b010;
        tick();
        chk("mid_new_grant", 16'(grant), 16'h2);
        chk("mid_hold_sel", 16'(sel), 16'hB);
        chk("mid_hold_seg", 16'(seg), 16'h88);
        tick();
        chk("mid_hold_seg2", 16'(seg), 16'h88);
        tick();
        chk("mid_blank_sel", 16'(sel), 16'hF);
        chk("mid_blank_seg", 16'(seg), 16'hFF);
        tick();
        chk("mid_d3_sel", 16'(sel), 16'h7);
        chk("mid_d3_seg", 16'(seg), 16'h92);

        // Reset during digit-2 DRIVE of owner 1
        repeat (12) tick();
        chk("pre_rst_sel", 16'(sel), 16'hB);
        chk("pre_rst_seg", 16'(seg), 16'hC6);
        rst = 1'b1;
        tick();
        chk("mrst_grant", 16'(grant), 16'h0);
        chk("mrst_sel", 16'(sel), 16'hF);
        chk("mrst_seg", 16'(seg), 16'hFF);
        rst = 1'b0;
        tick();
        chk("mrst_regrant", 16'(grant), 16'h2);
        chk("mrst_d0_sel", 16'(sel), 16'hF);
        repeat (4) tick();
        chk("mrst_d1_sel", 16'(sel), 16'hD);
        chk("mrst_d1_seg", 16'(seg), 16'h82);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter: HOLD_CYCLES, default 100_000_000, minimum grant tenure in clk cycles (1 s at 100 MHz).
REQ-002 Parameter: SCAN_CYCLES, default 100_000, length of one digit slot in clk cycles (1 ms).
REQ-003 Parameter: BLANK_CYCLES, default 1_000, blanking dead time at the start of each digit slot; must be less than SCAN_CYCLES.
REQ-004 Port: clk  in  1  100 MHz system clock; the block has a single clock domain.
REQ-005 Port: rst  in  1  reset, synchronous to clk, active-high.
REQ-006 Port: req  in  3  per-requester display request, level.
REQ-007 Port: data0, data1, data2  in  16 each  hex value offered by requesters 0, 1 and 2.
REQ-008 Port: grant  out  3  one-hot owner of the display; all zero when no requester owns it.
REQ-009 Port: sel  out  4  digit selector, active-low; bit 0 is the rightmost digit.
REQ-010 Port: seg  out  8  segment drivers, active-low; bits 0-6 are segments A-G, bit 7 is DP.

Function
REQ-011 Arbiter FSM has two states.
- IDLE: grant = 0.
- OWN: grant is one-hot.
REQ-012 IDLE with any req high: go to OWN on the next edge, granting the first active requester searching from rr_last+1 modulo 3.
- Latency: req rise to grant = 1 cycle.
REQ-013 On every new grant:
- rr_last is set to the granted index.
- hold counter is cleared.
REQ-014 In OWN, the hold counter increments every cycle and saturates at HOLD_CYCLES-1.
REQ-015 In OWN, if the owner's req is low:
- the grant is released on the next edge;
- the arbiter goes directly to the next active requester in round-robin order, or to IDLE if none is active.
- There is no idle gap when another requester is waiting.
REQ-016 In OWN, if the hold counter is saturated and another req is high, the grant rotates to the next active requester after the owner.
REQ-017 In OWN, if the hold has expired and no other req is high, the owner keeps the grant indefinitely.
REQ-018 Owner drop and a new request in the same cycle: handled by REQ-015 (the new requester is eligible).
REQ-019 Scan FSM runs continuously and is independent of the arbiter.
- Each slot: BLANK for BLANK_CYCLES, then DRIVE for SCAN_CYCLES-BLANK_CYCLES.
- Digit index increments 0→1→2→3→0 at the end of each slot.
REQ-020 BLANK phase: sel = 4'hF and seg = 8'hFF.
REQ-021 DRIVE phase with a grant:
- sel has only bit[digit] low;
- seg = hex glyph of the nibble data_owner[4*digit+3 : 4*digit];
- DP is off (seg[7] = 1).
REQ-022 The displayed nibble is sampled from the owner's data at BLANK→DRIVE entry and held for the rest of that slot.
REQ-023 A grant change mid-slot has no visible effect until the next slot's DRIVE phase.
REQ-024 DRIVE phase with no grant: sel = 4'hF and seg = 8'hFF.
REQ-025 Outputs sel, seg and grant are registered and glitch-free.

Reset
REQ-026 When rst is high at a clk edge:
- grant = 0, state = IDLE, rr_last = 2 (so requester 0 has first priority);
- hold counter = 0, digit = 0, scan phase = BLANK with its counter at 0;
- sel = 4'hF, seg = 8'hFF.
REQ-027 rst asserted mid-tenure or mid-slot aborts immediately to the REQ-026 state.
- Pending requests are re-arbitrated from the first cycle after rst deasserts.

Structure
REQ-028 A shared package holds:
- the requester count (3);
- the digit count (4);
- the blank constants SEL_OFF = 4'hF and SEG_OFF = 8'hFF.
REQ-029 Hex-to-segment decode is one combinational sub-module, nibble_seg: 4-bit in, 7 active-low segments out, glyphs 0-F.
REQ-030 Arbiter and scan FSM are separate always-blocks inside display_arbiter; there are no further sub-modules.

Verification (HOLD_CYCLES=8, SCAN_CYCLES=4, BLANK_CYCLES=1)
REQ-031 Reset arbitration: rst then req=3'b011 → grant=3'b001 one cycle after rst low; grant=3'b010 on the 9th cycle of tenure (hold saturated, req1 waiting).
REQ-032 Early release: owner req0 drops at cycle 3 with req2 high → grant=3'b100 on the next edge with no IDLE cycle.
REQ-033 Sole requester: req=3'b010 alone for 50 cycles → grant stays 3'b010; all req low → grant=0 next cycle and sel=4'hF in every subsequent DRIVE phase.
REQ-034 Scan sequence: owner data=16'h1A3F, checked over 16 cycles.
- BLANK cycles show sel=F, seg=FF.
- DRIVE phases show sel=E/D/B/7 with seg glyphs F, 3, A, 1 (7'h0E, 7'h30, 7'h08, 7'h79 on bits 6:0) and seg[7]=1.
REQ-035 Mid-slot switch: grant changes during a digit-2 DRIVE phase → that slot still shows the old owner's nibble; the digit-3 slot shows the new owner's data.
REQ-036 Reset mid-operation: rst asserted during DRIVE of digit 2 → next cycle grant=0, sel=F, seg=FF; digit restarts at 0 after release.
